// File: rtl/ram_pkg.sv
// Shared geometry, types and read-pipeline helper for the dual-port 16x8 RAM responder.
package ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  valid;
        logic  uninit;
        data_t data;
    } rd_pipe_t;

    localparam rd_pipe_t RD_PIPE_IDLE = '{valid: 1'b0, uninit: 1'b0, data: {DATA_W{1'b0}}};

    // A stage loads the upstream result only when it is valid; otherwise data holds and uninit drops.
    function automatic rd_pipe_t rd_pipe_advance(input rd_pipe_t cur, input rd_pipe_t upstream);
        rd_pipe_t nxt;
        nxt = cur;
        if (upstream.valid) begin
            nxt = upstream;
        end else begin
            nxt.valid  = 1'b0;
            nxt.uninit = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// RD_LAT-deep register pipeline carrying read results; synchronous flush on rst.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rd_pipe_t pipe_in,
    output rd_pipe_t pipe_out
);

    rd_pipe_t stage_q [RD_LAT];
    rd_pipe_t stage_d [RD_LAT];

    // Next-state for every stage: each one samples the stage in front of it.
    always_comb begin
        stage_d[0] = rd_pipe_advance(stage_q[0], pipe_in);
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = rd_pipe_advance(stage_q[i], stage_q[i-1]);
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= RD_PIPE_IDLE;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign pipe_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/ram_dp_core.sv
// Dual-port 16x8 RAM responder: one write and one read per cycle, write-first bypass,
// never-written tracking and saturating transaction counters. Geometry comes from ram_pkg.
module ram_dp_core
    import ram_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_enb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_uninit,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    data_t            mem_q [DEPTH];
    data_t            mem_d [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;
    logic             wr_fire;
    logic             rd_fire;
    logic             bypass;
    rd_pipe_t         rd_issue;
    rd_pipe_t         rd_out;

    assign wr_fire = wr_enb & ~rst;
    assign rd_fire = rd_enb & ~rst;
    assign bypass  = wr_fire & rd_fire & (wr_addr == rd_addr);

    // Write side: array update, written bitmap and saturating write count.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        wr_cnt_d  = wr_cnt_q;
        if (wr_fire) begin
            mem_d[wr_addr]     = wr_data;
            written_d[wr_addr] = 1'b1;
            if (wr_cnt_q != CNT_MAX) begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end else begin
                wr_cnt_d = wr_cnt_q;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // Read side: a same-address write wins, so the read sees new data and counts as initialised.
    always_comb begin
        rd_issue       = RD_PIPE_IDLE;
        rd_issue.valid = rd_fire;
        rd_cnt_d       = rd_cnt_q;
        if (bypass) begin
            rd_issue.data   = wr_data;
            rd_issue.uninit = 1'b0;
        end else begin
            rd_issue.data   = mem_q[rd_addr];
            rd_issue.uninit = ~written_q[rd_addr];
        end
        if (rd_fire && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Bitmap and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= {DEPTH{1'b0}};
            wr_cnt_q  <= {CNT_W{1'b0}};
            rd_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            written_q <= written_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    ram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .pipe_in  (rd_issue),
        .pipe_out (rd_out)
    );

    assign rd_data   = rd_out.data;
    assign rd_valid  = rd_out.valid;
    assign rd_uninit = rd_out.uninit;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_ram_dp_core.sv
// Bench for ram_dp_core: a latency-1/8-bit-counter instance and a latency-2/4-bit-counter
// instance share stimulus and are checked against a queue-based reference model.
module tb_ram_dp_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_enb = 1'b0;
    logic       rd_enb = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;

    logic [7:0] rd_data1, rd_data2;
    logic       rd_valid1, rd_valid2, rd_uninit1, rd_uninit2;
    logic [7:0] wr_cnt1, rd_cnt1;
    logic [3:0] wr_cnt2, rd_cnt2;

    always #5 clk = ~clk;

    ram_dp_core #(.RD_LAT(1), .CNT_W(8)) u_lat1 (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .rd_uninit(rd_uninit1), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1)
    );

    ram_dp_core #(.RD_LAT(2), .CNT_W(4)) u_lat2 (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .rd_uninit(rd_uninit2), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: memory image, written flags, raw totals, and a history of issued reads
    // (newest first); the result visible at latency L is history entry L-1.
    typedef struct {
        bit         v;
        bit         u;
        logic [7:0] d;
    } rec_t;

    rec_t       hist[$];
    logic [7:0] m_mem [16];
    bit         m_written [16];
    int         wr_total = 0;
    int         rd_total = 0;
    bit         e_v [2];
    bit         e_u [2];
    bit         e_dk [2];
    logic [7:0] e_d [2];

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic step(input bit rs, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input bit re, input logic [3:0] ra);
        rec_t r;
        rst = rs; wr_enb = we; wr_addr = wa; wr_data = wd; rd_enb = re; rd_addr = ra;
        @(posedge clk);
        r.v = re && !rs;
        if (we && re && (wa == ra)) begin
            r.d = wd; r.u = 1'b0;
        end else begin
            r.d = m_mem[ra]; r.u = !m_written[ra];
        end
        if (rs) begin
            hist.delete();
            foreach (m_written[i]) m_written[i] = 1'b0;
            wr_total = 0; rd_total = 0;
        end else begin
            if (we) begin m_mem[wa] = wd; m_written[wa] = 1'b1; wr_total++; end
            if (re) rd_total++;
        end
        hist.push_front(r);
        if (hist.size() > 2) void'(hist.pop_back());
        for (int l = 0; l < 2; l++) begin
            if (rs) begin
                e_v[l] = 1'b0; e_u[l] = 1'b0; e_d[l] = 8'h00; e_dk[l] = 1'b1;
            end else if (hist.size() > l && hist[l].v) begin
                e_v[l] = 1'b1; e_u[l] = hist[l].u; e_d[l] = hist[l].d; e_dk[l] = !hist[l].u;
            end else begin
                e_v[l] = 1'b0; e_u[l] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic test_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        step(1'b1, 1'b1, 4'd1, 8'hFF, 1'b1, 4'd1);
        step(1'b1, 1'b1, 4'd2, 8'hEE, 1'b1, 4'd2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({rd_valid1, rd_valid2, rd_uninit1, rd_uninit2} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_flags k=%0d: got v1=%b v2=%b u1=%b u2=%b, want all 0",
                         k, rd_valid1, rd_valid2, rd_uninit1, rd_uninit2);
            end
            vectors++;
            if (rd_data1 !== 8'h00 || rd_data2 !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_data k=%0d: got %h/%h, want 00/00", k, rd_data1, rd_data2);
            end
            vectors++;
            if (wr_cnt1 !== 8'd0 || rd_cnt1 !== 8'd0 || wr_cnt2 !== 4'd0 || rd_cnt2 !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_cnt k=%0d: got %0d %0d %0d %0d, want 0", k,
                         wr_cnt1, rd_cnt1, wr_cnt2, rd_cnt2);
            end
            idle();
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        vectors++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 8'hA5 || rd_uninit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_lat1: got v=%b d=%h u=%b, want v=1 d=a5 u=0", rd_valid1, rd_data1, rd_uninit1);
        end
        vectors++;
        if (wr_cnt1 !== 8'd1 || rd_cnt1 !== 8'd1) begin
            miscompares++;
            $display("FAIL wr_rd_cnt: got wr=%0d rd=%0d, want 1 1", wr_cnt1, rd_cnt1);
        end
        vectors++;
        if (rd_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_lat2_early: got v=%b, want 0", rd_valid2);
        end
        idle();
        vectors++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 8'hA5 || rd_uninit2 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_lat2: got v=%b d=%h u=%b, want v=1 d=a5 u=0", rd_valid2, rd_data2, rd_uninit2);
        end
        vectors++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_rd_hold: got v=%b d=%h, want v=0 d=a5", rd_valid1, rd_data1);
        end
    endtask

    task automatic test_bypass();
        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        vectors++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h3C || rd_uninit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_lat1: got v=%b d=%h u=%b, want v=1 d=3c u=0", rd_valid1, rd_data1, rd_uninit1);
        end
        idle();
        vectors++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 8'h3C || rd_uninit2 !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_lat2: got v=%b d=%h u=%b, want v=1 d=3c u=0", rd_valid2, rd_data2, rd_uninit2);
        end
    endtask

    task automatic test_uninit();
        step(1'b0, 1'b1, 4'd4, 8'h44, 1'b1, 4'd9);
        vectors++;
        if (rd_valid1 !== 1'b1 || rd_uninit1 !== 1'b1) begin
            miscompares++;
            $display("FAIL uninit_lat1: got v=%b u=%b, want v=1 u=1", rd_valid1, rd_uninit1);
        end
        idle();
        vectors++;
        if (rd_valid2 !== 1'b1 || rd_uninit2 !== 1'b1) begin
            miscompares++;
            $display("FAIL uninit_lat2: got v=%b u=%b, want v=1 u=1", rd_valid2, rd_uninit2);
        end
    endtask

    task automatic test_lat2_burst();
        logic [7:0] want_d [5];
        bit         want_v [5];
        want_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        want_d = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h00};
        for (int a = 0; a < 3; a++) step(1'b0, 1'b1, 4'(a), 8'(8'h10 + a), 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(k));
            else idle();
            vectors++;
            if (rd_valid2 !== want_v[k] || (want_v[k] && rd_data2 !== want_d[k])) begin
                miscompares++;
                $display("FAIL lat2_burst k=%0d: got v=%b d=%h, want v=%b d=%h",
                         k, rd_valid2, rd_data2, want_v[k], want_d[k]);
            end
        end
    endtask

    task automatic test_lat2_reset();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        vectors++;
        if (rd_valid2 !== 1'b0 || rd_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midpipe_rst: got v1=%b v2=%b, want 0 0", rd_valid1, rd_valid2);
        end
        idle();
        vectors++;
        if (rd_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL midpipe_rst_after: got v2=%b, want 0", rd_valid2);
        end
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
        idle();
        vectors++;
        if (rd_valid2 !== 1'b1 || rd_uninit2 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_clears_written: got v=%b u=%b, want v=1 u=1", rd_valid2, rd_uninit2);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 4'd0);
            vectors++;
            if (wr_cnt2 !== 4'(sat(i, 4)) || wr_cnt1 !== 8'(sat(i, 8))) begin
                miscompares++;
                $display("FAIL wr_cnt_sat i=%0d: got %0d/%0d, want %0d/%0d",
                         i, wr_cnt1, wr_cnt2, sat(i, 8), sat(i, 4));
            end
        end
    endtask

    task automatic test_random();
        logic       ov, ou;
        logic [7:0] od;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                 8'($urandom), $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
            for (int l = 0; l < 2; l++) begin
                ov = (l == 0) ? rd_valid1 : rd_valid2;
                ou = (l == 0) ? rd_uninit1 : rd_uninit2;
                od = (l == 0) ? rd_data1 : rd_data2;
                vectors++;
                if (ov !== e_v[l] || (e_v[l] && ou !== e_u[l]) || (e_dk[l] && od !== e_d[l])) begin
                    miscompares++;
                    $display("FAIL random_rd n=%0d lat=%0d: got v=%b u=%b d=%h, want v=%b u=%b d=%h",
                             n, l + 1, ov, ou, od, e_v[l], e_u[l], e_d[l]);
                end
            end
            vectors++;
            if (wr_cnt1 !== 8'(sat(wr_total, 8)) || rd_cnt1 !== 8'(sat(rd_total, 8)) ||
                wr_cnt2 !== 4'(sat(wr_total, 4)) || rd_cnt2 !== 4'(sat(rd_total, 4))) begin
                miscompares++;
                $display("FAIL random_cnt n=%0d: got %0d %0d %0d %0d, want %0d %0d %0d %0d", n,
                         wr_cnt1, rd_cnt1, wr_cnt2, rd_cnt2, sat(wr_total, 8), sat(rd_total, 8),
                         sat(wr_total, 4), sat(rd_total, 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_uninit();
        test_lat2_burst();
        test_lat2_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
